pll_clk_gen: RTL and testbench

//  Synthesizable clock-generation block standing in for the high-speed PLL wrapper.

---
 rtl/pll_clk_pkg.sv | 15 +
 rtl/clk_div_even.sv | 45 ++++
 rtl/pll_clk_gen.sv | 64 ++++++
 tb/tb_pll_clk_gen.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/pll_clk_pkg.sv
// pll_clk_pkg: shared constants for the clock-generation block.
//   Default lock settle time and divider ratios, plus a helper that sizes
//   a counter so it can hold 0..max_val (never narrower than one bit).
package pll_clk_pkg;

    localparam int DEF_LOCK_CYCLES = 256;
    localparam int DEF_DIV0        = 2;
    localparam int DEF_DIV1        = 4;
    localparam int DEF_DIV5        = 8;

    function automatic int cnt_width(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/clk_div_even.sv
// clk_div_even: even-ratio, 50 %-duty clock divider, output straight from a flop.
//   clk      in   reference clock (all flops on its rising edge)
//   rst_n    in   asynchronous active-low reset
//   en       in   run enable; while low the counter and output are held at 0
//   clk_out  out  clk / DIV, first rising edge DIV/2 enabled rises after en goes high
module clk_div_even
    import pll_clk_pkg::*;
#(
    parameter int DIV = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic clk_out
);

    localparam int HALF = DIV / 2;
    localparam int CW   = cnt_width(HALF - 1);
    localparam logic [CW-1:0] LAST = CW'(HALF - 1);

    generate
        if (DIV < 2 || (DIV % 2) != 0) begin : g_bad_div
            $error("clk_div_even: DIV must be even and >= 2");
        end
    endgenerate

    logic [CW-1:0] cnt;

    // Toggle every HALF rises: high and low phases are both HALF cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            clk_out <= 1'b0;
        end else if (!en) begin
            cnt     <= '0;
            clk_out <= 1'b0;
        end else if (cnt == LAST) begin
            cnt     <= '0;
            clk_out <= ~clk_out;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/pll_clk_gen.sv
// pll_clk_gen: synthesizable stand-in for the PLL wrapper.
//   clkin1     in   reference clock, the only clock in the block
//   pll_rst_n  in   asynchronous active-low reset
//   clkout0    out  clkin1 / DIV0, 50 % duty, held low until lock
//   clkout1    out  clkin1 / DIV1, 50 % duty, held low until lock
//   clkout5    out  clkin1 / DIV5, 50 % duty, held low until lock
//   pll_lock   out  sticky lock flag, high LOCK_CYCLES rises after reset release
module pll_clk_gen
    import pll_clk_pkg::*;
#(
    parameter real CLKIN_FREQ  = 65.0,
    parameter int  LOCK_CYCLES = DEF_LOCK_CYCLES,
    parameter int  DIV0        = DEF_DIV0,
    parameter int  DIV1        = DEF_DIV1,
    parameter int  DIV5        = DEF_DIV5
) (
    input  logic clkin1,
    input  logic pll_rst_n,
    output logic clkout0,
    output logic clkout1,
    output logic clkout5,
    output logic pll_lock
);

    localparam int LW = cnt_width(LOCK_CYCLES);
    localparam logic [LW-1:0] LOCK_LAST = LW'(LOCK_CYCLES - 1);

    generate
        if (LOCK_CYCLES < 1) begin : g_bad_lock
            $error("pll_clk_gen: LOCK_CYCLES must be >= 1");
        end
        if (CLKIN_FREQ <= 0.0) begin : g_bad_freq
            $error("pll_clk_gen: CLKIN_FREQ must be positive");
        end
    endgenerate

    logic [LW-1:0] lock_cnt;

    // Counter runs only until lock; lock is set on the rise that sees the
    // last pre-lock count, so it is high after exactly LOCK_CYCLES rises.
    // After that nothing but reset can touch either register.
    always_ff @(posedge clkin1 or negedge pll_rst_n) begin
        if (!pll_rst_n) begin
            lock_cnt <= '0;
            pll_lock <= 1'b0;
        end else if (!pll_lock) begin
            lock_cnt <= lock_cnt + 1'b1;
            if (lock_cnt == LOCK_LAST) pll_lock <= 1'b1;
        end
    end

    clk_div_even #(.DIV(DIV0)) u_div0 (
        .clk(clkin1), .rst_n(pll_rst_n), .en(pll_lock), .clk_out(clkout0)
    );

    clk_div_even #(.DIV(DIV1)) u_div1 (
        .clk(clkin1), .rst_n(pll_rst_n), .en(pll_lock), .clk_out(clkout1)
    );

    clk_div_even #(.DIV(DIV5)) u_div5 (
        .clk(clkin1), .rst_n(pll_rst_n), .en(pll_lock), .clk_out(clkout5)
    );

endmodule

// File: tb/tb_pll_clk_gen.sv
`timescale 1ns/1ps
// tb_pll_clk_gen: two instances (default parameters and a sweep set) share
// clock and reset. Expected {lock,clkout0,clkout1,clkout5} comes from a
// closed-form function of the number of rises since reset release.
module tb_pll_clk_gen;

    logic clkin1 = 1'b0;
    logic pll_rst_n = 1'b0;

    logic d_c0, d_c1, d_c5, d_lock;
    logic s_c0, s_c1, s_c5, s_lock;

    always #7.692 clkin1 = ~clkin1;

    pll_clk_gen u_dflt (
        .clkin1(clkin1), .pll_rst_n(pll_rst_n),
        .clkout0(d_c0), .clkout1(d_c1), .clkout5(d_c5), .pll_lock(d_lock)
    );

    pll_clk_gen #(.LOCK_CYCLES(1), .DIV0(2), .DIV1(6), .DIV5(10)) u_sweep (
        .clkin1(clkin1), .pll_rst_n(pll_rst_n),
        .clkout0(s_c0), .clkout1(s_c1), .clkout5(s_c5), .pll_lock(s_lock)
    );

    int vectors = 0;
    int miscompares = 0;
    int n = 0;            // clkin1 rises since reset release
    bit track = 1'b0;
    int lock_edges = 0;

    typedef struct {
        logic [3:0] dflt;
        logic [3:0] sweep;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        int         rises;
        logic [3:0] dflt;   // {lock, c0, c1, c5}
    } vec_t;

    // After lock at rise L, output toggles every h rises starting h rises later.
    function automatic logic [3:0] model(int rises, int l, int h0, int h1, int h5);
        int k;
        if (rises < l) return 4'b0000;
        k = rises - l;
        return {1'b1, 1'((k / h0) % 2), 1'((k / h1) % 2), 1'((k / h5) % 2)};
    endfunction

    task automatic check(string name, logic [3:0] act, logic [3:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %b expected %b (rises=%0d, t=%0t)", name, act, req, n, $time);
        end
    endtask

    always @(posedge d_lock) lock_edges++;

    always @(posedge clkin1) begin
        if (track) begin
            n = n + 1;
            sb.push_back('{dflt: model(n, 256, 1, 2, 4), sweep: model(n, 1, 1, 3, 5)});
        end
    end

    always @(negedge clkin1) begin
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check("sb_dflt",  {d_lock, d_c0, d_c1, d_c5}, e.dflt);
            check("sb_sweep", {s_lock, s_c0, s_c1, s_c5}, e.sweep);
        end
    end

    task automatic stop_tracking();
        @(negedge clkin1);
        #2;
        track = 1'b0;
        sb.delete();
    endtask

    task automatic release_reset();
        @(negedge clkin1);
        pll_rst_n = 1'b1;
        n = 0;
        lock_edges = 0;
        track = 1'b1;
    endtask

    task automatic wait_rises(int target);
        int guard = 0;
        while (n < target && guard < 5000) begin
            @(negedge clkin1);
            guard++;
        end
    endtask

    vec_t tbl[10];
    int hi0, hi1, hi5;

    initial begin
        tbl[0] = '{1,   4'b0000};
        tbl[1] = '{255, 4'b0000};
        tbl[2] = '{256, 4'b1000};
        tbl[3] = '{257, 4'b1100};
        tbl[4] = '{258, 4'b1010};
        tbl[5] = '{259, 4'b1110};
        tbl[6] = '{260, 4'b1001};
        tbl[7] = '{261, 4'b1101};
        tbl[8] = '{262, 4'b1011};
        tbl[9] = '{264, 4'b1000};

        // Reset held with the clock running: everything low, before and after edges.
        #1;
        check("rst_t0_dflt",  {d_lock, d_c0, d_c1, d_c5}, 4'b0000);
        check("rst_t0_sweep", {s_lock, s_c0, s_c1, s_c5}, 4'b0000);
        repeat (2) begin
            @(negedge clkin1);
            check("rst_hold_dflt",  {d_lock, d_c0, d_c1, d_c5}, 4'b0000);
            check("rst_hold_sweep", {s_lock, s_c0, s_c1, s_c5}, 4'b0000);
        end

        release_reset();

        // Lock timing and output phase checkpoints.
        for (int i = 0; i < 10; i++) begin
            wait_rises(tbl[i].rises);
            vectors++;
            if (n != tbl[i].rises) begin
                miscompares++;
                $display("FAIL tbl_wait[%0d]: reached rises=%0d expected %0d", i, n, tbl[i].rises);
            end else begin
                check($sformatf("tbl[%0d]", i), {d_lock, d_c0, d_c1, d_c5}, tbl[i].dflt);
            end
        end

        // Duty: over 64 rises (a multiple of every period) each output is high half the time.
        hi0 = 0; hi1 = 0; hi5 = 0;
        repeat (64) begin
            @(negedge clkin1);
            hi0 += int'(d_c0); hi1 += int'(d_c1); hi5 += int'(d_c5);
        end
        check("duty_c0", 4'(hi0 / 4), 4'd8);
        check("duty_c1", 4'(hi1 / 4), 4'd8);
        check("duty_c5", 4'(hi5 / 4), 4'd8);

        // Long run: lock must stay up, exactly one lock edge.
        wait_rises(2000);
        check("lock_edges_1", 4'(lock_edges), 4'd1);

        // Mid-run async reset, asserted away from any clock edge.
        stop_tracking();
        #1;
        pll_rst_n = 1'b0;
        #1;
        check("async_rst_dflt",  {d_lock, d_c0, d_c1, d_c5}, 4'b0000);
        check("async_rst_sweep", {s_lock, s_c0, s_c1, s_c5}, 4'b0000);
        #10;
        check("rst_10ns_dflt", {d_lock, d_c0, d_c1, d_c5}, 4'b0000);
        release_reset();
        wait_rises(255);
        check("relock_255", {d_lock, d_c0, d_c1, d_c5}, 4'b0000);
        wait_rises(256);
        check("relock_256", {d_lock, d_c0, d_c1, d_c5}, 4'b1000);
        wait_rises(600);
        check("lock_edges_2", 4'(lock_edges), 4'd1);

        stop_tracking();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
